// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - serialises 32-bit bitstream words MSB-first onto the Core programming chain
module cfg_chain_loader #(
   parameter int CHAIN_LEN = 4096,
   parameter int CNT_W     = 16
) (
   input  logic        prog_clk,
   input  logic        prog_rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] cfg_data,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   output logic        prog_in_o,
   output logic        prog_en_o,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

   state_t           state, state_nxt;
   logic [31:0]      shreg, shreg_nxt;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt, bit_cnt_inc;
   logic [4:0]       word_bits, word_bits_nxt;

   assign bit_cnt_inc = bit_cnt + CNT_W'(1);

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         word_bits <= '0;
         prog_en_o <= 1'b0;
         prog_in_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         bit_cnt   <= bit_cnt_nxt;
         word_bits <= word_bits_nxt;
         // Chain pins are registered from the next-state view so the Core never sees an input-to-pin path
         prog_en_o <= (state_nxt == ST_SHIFT);
         prog_in_o <= (state_nxt == ST_SHIFT) & shreg_nxt[31];
      end
   end

   always_comb begin
      state_nxt     = state;
      shreg_nxt     = shreg;
      bit_cnt_nxt   = bit_cnt;
      word_bits_nxt = word_bits;
      cfg_ready     = (state == ST_LOAD) && !abort;
      busy          = (state == ST_LOAD) || (state == ST_SHIFT);
      done          = (state == ST_DONE);

      if (abort) begin
         state_nxt   = ST_IDLE;
         bit_cnt_nxt = '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_nxt   = ST_LOAD;
                  bit_cnt_nxt = '0;
               end
            end
            ST_LOAD: begin
               if (cfg_valid) begin
                  shreg_nxt     = cfg_data;
                  word_bits_nxt = '0;
                  state_nxt     = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               shreg_nxt     = {shreg[30:0], 1'b0};
               bit_cnt_nxt   = bit_cnt_inc;
               word_bits_nxt = word_bits + 5'd1;
               // Chain end wins over word end, so a partial last word is simply dropped
               if (bit_cnt_inc == LAST_CNT) begin
                  state_nxt = ST_DONE;
               end else if (word_bits == 5'd31) begin
                  state_nxt = ST_LOAD;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb/tb_cfg_chain_loader.sv - directed vector bench for cfg_chain_loader
module tb_cfg_chain_loader;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, cfg_valid;
   logic [31:0] cfg_data;
   logic        ready_a, in_a, en_a, busy_a, done_a;
   logic        ready_b, in_b, en_b, busy_b, done_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cfg_chain_loader #(.CHAIN_LEN(40), .CNT_W(16)) u40 (
      .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .abort(abort),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
      .prog_in_o(in_a), .prog_en_o(en_a), .busy(busy_a), .done(done_a));

   cfg_chain_loader #(.CHAIN_LEN(32), .CNT_W(6)) u32 (
      .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .abort(abort),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
      .prog_in_o(in_b), .prog_en_o(en_b), .busy(busy_b), .done(done_b));

   // Chain observer: samples on the falling edge, mid-way through each shift cycle
   int          cyc = 0;
   int          en_cnt_a = 0, en_cnt_b = 0, hs_a = 0, hs_b = 0, load_a = 0, rdy_b = 0;
   int          last_en_a = 0, last_en_b = 0, done_rise_a = 0, done_rise_b = 0;
   logic [63:0] str_a = '0, str_b = '0;
   logic        done_pa = 1'b0, done_pb = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (en_a) begin
         en_cnt_a  <= en_cnt_a + 1;
         str_a     <= {str_a[62:0], in_a};
         last_en_a <= cyc;
      end
      if (en_b) begin
         en_cnt_b  <= en_cnt_b + 1;
         str_b     <= {str_b[62:0], in_b};
         last_en_b <= cyc;
      end
      if (cfg_valid && ready_a) hs_a <= hs_a + 1;
      if (cfg_valid && ready_b) hs_b <= hs_b + 1;
      if (busy_a && !en_a) load_a <= load_a + 1;
      if (ready_b) rdy_b <= rdy_b + 1;
      if (done_a && !done_pa) done_rise_a <= cyc;
      if (done_b && !done_pb) done_rise_b <= cyc;
      done_pa <= done_a;
      done_pb <= done_b;
   end

   typedef struct {
      logic        st;
      logic        ab;
      logic        vl;
      logic [31:0] d;
      logic [4:0]  exp;   // {cfg_ready, prog_en_o, prog_in_o, busy, done}
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input int stall);
      int n = 0;
      while (!ready_a && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got %0d cycles expected <200", n);
      end
      repeat (stall) step();
      cfg_valid = 1'b1;
      cfg_data  = d;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done(input bit sel_b);
      int n = 0;
      while (!(sel_b ? done_b : done_a) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got %0d cycles expected <300", n);
      end
      step();
   endtask

   initial begin
      int s_en, s_hs, s_ld, s_rdy;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;

      tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'b00000};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'b00000};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'b10010};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'b00010};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'b00000};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'b00000};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h8000_0000, 5'b10010};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'b01110};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'b01010};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 5'b01010};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'b00000};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h1234_5678, 5'b00000};

      for (int i = 0; i < 3; i++) begin
         start = (i % 2 == 0);
         cfg_valid = 1'b1;
         step();
         chk("reset_hold", {ready_a, en_a, in_a, busy_a, done_a, ready_b, en_b, in_b, busy_b, done_b}, 64'd0);
      end
      start = 1'b0; cfg_valid = 1'b0;
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 12; i++) begin
         start = tbl[i].st; abort = tbl[i].ab; cfg_valid = tbl[i].vl; cfg_data = tbl[i].d;
         #1;
         chk($sformatf("vec%0d", i), {ready_a, en_a, in_a, busy_a, done_a}, tbl[i].exp);
         step();
      end
      start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;

      // One exact word on the 32-bit chain
      do_abort();
      s_en = en_cnt_b; s_hs = hs_b; s_rdy = rdy_b;
      pulse_start();
      send_word(32'hA500_0001, 0);
      wait_done(1'b1);
      chk("full_en_cycles", en_cnt_b - s_en, 32);
      chk("full_stream", str_b[31:0], 32'hA500_0001);
      chk("full_handshakes", hs_b - s_hs, 1);
      chk("full_ready_cycles", rdy_b - s_rdy, 1);
      chk("full_done_latency", done_rise_b - last_en_b, 1);

      // Partial last word on the 40-bit chain
      do_abort();
      s_en = en_cnt_a; s_hs = hs_a; s_ld = load_a;
      pulse_start();
      send_word(32'hFFFF_FFFF, 0);
      send_word(32'hC000_0000, 0);
      wait_done(1'b0);
      chk("part_en_cycles", en_cnt_a - s_en, 40);
      chk("part_stream", str_a[39:0], {32'hFFFF_FFFF, 8'hC0});
      chk("part_handshakes", hs_a - s_hs, 2);
      chk("part_load_cycles", load_a - s_ld, 2);
      chk("part_done_latency", done_rise_a - last_en_a, 1);

      // Second word held back by 10 cycles
      do_abort();
      s_en = en_cnt_a; s_ld = load_a;
      pulse_start();
      send_word(32'h1234_5678, 0);
      send_word(32'h9A00_0000, 10);
      wait_done(1'b0);
      chk("stall_en_cycles", en_cnt_a - s_en, 40);
      chk("stall_stream", str_a[39:0], {32'h1234_5678, 8'h9A});
      chk("stall_load_cycles", load_a - s_ld, 12);

      // Abort on bit 17, then a fresh session
      do_abort();
      s_en = en_cnt_a;
      pulse_start();
      send_word(32'hDEAD_BEEF, 0);
      repeat (16) step();
      do_abort();
      chk("abort_outputs", {ready_a, en_a, in_a, busy_a, done_a}, 5'b00000);
      chk("abort_bits", en_cnt_a - s_en, 17);
      s_en = en_cnt_a;
      pulse_start();
      send_word(32'h0F0F_0F0F, 0);
      send_word(32'h5500_0000, 0);
      wait_done(1'b0);
      chk("reload_en_cycles", en_cnt_a - s_en, 40);
      chk("reload_stream", str_a[39:0], {32'h0F0F_0F0F, 8'h55});

      // Start during SHIFT is ignored; start in DONE restarts
      do_abort();
      s_en = en_cnt_a; s_hs = hs_a;
      pulse_start();
      send_word(32'hA0A0_A0A0, 0);
      repeat (5) step();
      pulse_start();
      send_word(32'h3C00_0000, 0);
      wait_done(1'b0);
      chk("ign_en_cycles", en_cnt_a - s_en, 40);
      chk("ign_stream", str_a[39:0], {32'hA0A0_A0A0, 8'h3C});
      chk("ign_handshakes", hs_a - s_hs, 2);
      pulse_start();
      chk("restart_from_done", {busy_a, done_a}, 2'b10);

      // Asynchronous reset while shifting
      do_abort();
      pulse_start();
      send_word(32'hFFFF_FFFF, 0);
      step();
      chk("pre_rst_en", en_a, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", {ready_a, en_a, in_a, busy_a, done_a}, 5'b00000);
      step();
      rst_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

endmodule
